// File: rtl/mux_pkg.sv
// Shared select/counter definitions for the datapath glue muxes.
// Used by mux_1bit_sel and its optional toggle counter.
package mux_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int CNT_W_DEF = 8;
  localparam int CNT_W_MIN = 2;
  localparam int CNT_W_MAX = 16;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  // Saturating increment; holds at all-ones.
  function automatic cnt_t cnt_sat_inc(
    input cnt_t c
  );
    return (c == '1) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/mux_sel_toggle_counter.sv
// Saturating counter of select-line changes, debug visibility only.
// Built only with MUX_1BIT_SEL_TOGGLE_CNT_EN.
module mux_sel_toggle_counter
  import mux_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  output logic [CNT_W-1:0] cnt
);

  logic sel_prev;
  logic toggle;
  logic sat;

  assign toggle = sel != sel_prev;
  assign sat    = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_prev <= 1'b0;
      cnt      <= '0;
    end else begin
      sel_prev <= sel;
      if (toggle && !sat)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux_1bit_sel.sv
// Single-bit 2:1 selector with combinational and registered outputs.
// Optional sel toggle counter: define MUX_1BIT_SEL_TOGGLE_CNT_EN.
module mux_1bit_sel
  import mux_pkg::*;
#(
  parameter logic SEL_B_VAL = SEL_B,
  parameter int   CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  input  logic             sel,
`ifdef MUX_1BIT_SEL_TOGGLE_CNT_EN
  output logic             Q,
  output logic             Q_q,
  output logic [CNT_W-1:0] sel_toggle_cnt
`else
  output logic             Q,
  output logic             Q_q
`endif
);

  logic s;

  assign s = (sel == SEL_B_VAL);

  // Consensus term keeps Q stable (and non-X) when A == B.
  assign Q = (A & ~s) | (B & s) | (A & B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      Q_q <= 1'b0;
    else
      Q_q <= Q;
  end

`ifdef MUX_1BIT_SEL_TOGGLE_CNT_EN
  mux_sel_toggle_counter #(
    .CNT_W (CNT_W)
  ) u_tcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .sel   (sel),
    .cnt   (sel_toggle_cnt)
  );
`endif

endmodule

// File: tb/tb_mux_1bit_sel.sv
// Directed self-checking bench for mux_1bit_sel.
// Counter checks run when MUX_1BIT_SEL_TOGGLE_CNT_EN is defined.
module tb_mux_1bit_sel;

  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic A, B, sel;
  logic Q, Q_q;
`ifdef MUX_1BIT_SEL_TOGGLE_CNT_EN
  logic [CNT_W-1:0] sel_toggle_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_1bit_sel #(
    .SEL_B_VAL (1'b1),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .A              (A),
    .B              (B),
    .sel            (sel),
`ifdef MUX_1BIT_SEL_TOGGLE_CNT_EN
    .Q              (Q),
    .Q_q            (Q_q),
    .sel_toggle_cnt (sel_toggle_cnt)
`else
    .Q              (Q),
    .Q_q            (Q_q)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    A = 1'b0; B = 1'b0; sel = 1'b0;
    #1;
    chk("rst_q", 16'(Q), 16'h0);
    chk("rst_qq", 16'(Q_q), 16'h0);
    after_edge();
    chk("rst_qq_edge", 16'(Q_q), 16'h0);
    @(negedge clk) rst_n = 1'b1;
    after_edge();
    chk("rel_qq", 16'(Q_q), 16'h0);

    @(negedge clk);
    A = 1'b1; B = 1'b0; sel = 1'b0;
    #1;
    chk("a1_q", 16'(Q), 16'h1);
    chk("a1_qq_pre", 16'(Q_q), 16'h0);
    after_edge();
    chk("a1_qq", 16'(Q_q), 16'h1);
    @(negedge clk) sel = 1'b1;
    #1;
    chk("a1s1_q", 16'(Q), 16'h0);
    after_edge();
    chk("a1s1_qq", 16'(Q_q), 16'h0);

    @(negedge clk);
    A = 1'b0; B = 1'b1; sel = 1'b0;
    #1;
    chk("b1s0_q", 16'(Q), 16'h0);
    sel = 1'b1;
    #1;
    chk("b1s1_q", 16'(Q), 16'h1);
    after_edge();
    chk("b1s1_qq", 16'(Q_q), 16'h1);

    @(negedge clk);
    A = 1'b1; B = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sel = ~sel;
      #1;
      chk("cons_q", 16'(Q), 16'h1);
      #4;
    end
    after_edge();
    chk("cons_qq", 16'(Q_q), 16'h1);
    sel = 1'bx;
    #1;
    chk("cons_x_q", 16'(Q), 16'h1);
    after_edge();
    chk("cons_x_qq", 16'(Q_q), 16'h1);

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_qq", 16'(Q_q), 16'h0);
    chk("mid_rst_q", 16'(Q), 16'h1);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("mid_rel_qq_pre", 16'(Q_q), 16'h0);
    after_edge();
    chk("mid_rel_qq", 16'(Q_q), 16'h1);

    @(negedge clk);
    A = 1'b0; B = 1'b1; sel = 1'b0;
    #1;
    chk("simul_q", 16'(Q), 16'h0);
    after_edge();
    chk("simul_qq", 16'(Q_q), 16'h0);
    @(negedge clk);
    A = 1'b1; B = 1'b0; sel = 1'b1;
    after_edge();
    chk("simul2_qq", 16'(Q_q), 16'h0);
    @(negedge clk) sel = 1'b0;
    after_edge();
    chk("simul3_qq", 16'(Q_q), 16'h1);

`ifdef MUX_1BIT_SEL_TOGGLE_CNT_EN
    @(negedge clk);
    sel = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("cnt_rst", 16'(sel_toggle_cnt), 16'h0);
    @(negedge clk) rst_n = 1'b1;
    after_edge();
    chk("cnt_idle", 16'(sel_toggle_cnt), 16'h0);
    begin
      logic [CNT_W-1:0] exp_cnt [5];
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 5; i++) begin
        @(negedge clk) sel = ~sel;
        after_edge();
        chk("cnt_sat", 16'(sel_toggle_cnt), 16'(exp_cnt[i]));
      end
    end
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("cnt_clr", 16'(sel_toggle_cnt), 16'h0);
    @(negedge clk) rst_n = 1'b1;
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_1bit_sel.md
Name: mux_1bit_sel

Overview:
- Single-bit 2:1 selector for the 16-bit processor datapath/control glue: sel=0 passes A, sel=1 passes B.
- Provides a combinational output Q and a registered copy Q_q for timing-critical consumers.
- Optionally counts sel transitions for debug and coverage visibility.

Parameters:
- SEL_B_VAL, 1'b1: sel level that selects B. The other level selects A.
- CNT_W, 8: width of the optional sel-toggle counter. Legal range is 2..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low, synchronous deassert handled upstream.
- A  input  1  data input selected when sel != SEL_B_VAL.
- B  input  1  data input selected when sel == SEL_B_VAL.
- sel  input  1  select.
- Q  output  1  combinational mux result.
- Q_q  output  1  registered mux result.
- sel_toggle_cnt  output  CNT_W  number of sel changes, saturating. Present only with the optional feature.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Q, combinational, zero latency:
  - Q = B when sel == SEL_B_VAL, else A.
  - Independent of clk and rst_n.
- Consensus rule: when A == B, Q = A regardless of sel.
  - Implement as Q = (A & ~s) | (B & s) | (A & B), where s = (sel == SEL_B_VAL).
  - This keeps Q glitch-free across sel changes when both inputs agree.
  - Simulation must not yield X on Q when A == B and sel is X.
- Q_q, registered:
  - Captures the Q value on every rising clk edge; one-cycle latency.
  - Reset value 1'b0, forced immediately on rst_n falling (asynchronous).
- Undriven inputs: inputs may be X or undriven before the first vector.
  - Q_q is 0 while rst_n = 0.
  - After reset, Q_q follows Q with one-cycle latency.
- Reset mid-operation: Q_q clears to 0 asynchronously and Q is unaffected. On release, Q_q loads the current Q at the next edge.
- Simultaneous change of A/B/sel in the same cycle: Q_q reflects the new combinational value at the next edge. No ordering dependence.
- No handshake and no enable: the block samples every cycle.

Optional Feature:
- Macro MUX_1BIT_SEL_TOGGLE_CNT_EN.
- Defined:
  - Adds a sel_prev register (reset 0) and the sel_toggle_cnt port (reset 0).
  - Each rising edge with sel != sel_prev increments the count.
  - The count saturates at 2^CNT_W-1 with no wrap.
  - Both registers clear asynchronously on rst_n = 0.
  - The first edge after reset counts a toggle if sel = 1.
- Not defined:
  - Port and registers are absent.
  - Q and Q_q behaviour is identical in both builds.

Decomposition:
- Shared package mux_pkg holds:
  - localparams SEL_A = 1'b0 and SEL_B = 1'b1.
  - Default CNT_W constant.
  - Typedef for the counter width, used by other datapath muxes.
- Optional sub-module mux_sel_toggle_counter (clk, rst_n, sel, cnt), instantiated only under the macro. The core mux logic stays inline.

Test Plan:
- Reset then A=0,B=0,sel=0 → Q=0; Q_q=0 during reset and 0 one edge after release.
- A=1,B=0,sel=0 → Q=1 immediately; Q_q=1 after the next rising edge. Then sel=1 → Q=0, Q_q=0 one edge later.
- A=0,B=1,sel=0 → Q=0. Then sel=1 → Q=1.
- Consensus: A=1,B=1 with sel toggling every 5 ns, and again with sel=X → Q stays 1 with no glitch/X; Q_q=1.
- Assert rst_n=0 mid-cycle while Q=1 → Q_q drops to 0 without waiting for a clock and Q stays 1. Release → Q_q=1 after one edge.
- Macro defined, CNT_W=2: toggle sel on 5 consecutive edges → sel_toggle_cnt reads 1,2,3,3,3 (saturates). rst_n=0 → 0.
